// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, two-entry skid buffer and flush.
// Define PIPE_STAGE_PERF_EN to add the stall/flush performance counters.
module pipe_stage_skid #(
  parameter int CTRL_W = 3,
  parameter int DATA_W = 101
`ifdef PIPE_STAGE_PERF_EN
  ,
  parameter int CNT_W  = 16
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
  ,
  input  logic              perf_clr,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);

  // Occupancy encoded as {m_valid, s_valid}; 2'b01 can never be reached.
  typedef enum logic [1:0] {
    EMPTY   = 2'b00,
    ILLEGAL = 2'b01,
    BUSY    = 2'b10,
    FULL    = 2'b11
  } occ_e;

  logic              m_valid, s_valid;
  logic [CTRL_W-1:0] m_ctrl, s_ctrl;
  logic [DATA_W-1:0] m_data, s_data;
  logic              in_fire, out_fire;
  occ_e              occ;

  // in_ready comes straight from a flop, so there is no path from out_ready.
  assign in_ready  = !s_valid;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = m_valid && out_ready;
  assign occ       = occ_e'({m_valid, s_valid});

  assign out_valid = m_valid;
  assign out_data  = m_data;
  assign out_ctrl  = m_valid ? m_ctrl : '0;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side below reads the pre-edge values of the registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
      m_ctrl  <= '0;
      s_ctrl  <= '0;
      m_data  <= '0;
      s_data  <= '0;
    end else if (flush) begin
      // Data registers keep their contents; only the valids are killed.
      m_valid <= 1'b0;
      s_valid <= 1'b0;
    end else begin
      unique case (occ)
        EMPTY: begin
          if (in_fire) begin
            m_valid <= 1'b1;
            m_ctrl  <= in_ctrl;
            m_data  <= in_data;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            m_ctrl <= in_ctrl;
            m_data <= in_data;
          end else if (in_fire) begin
            s_valid <= 1'b1;
            s_ctrl  <= in_ctrl;
            s_data  <= in_data;
          end else if (out_fire) begin
            m_valid <= 1'b0;
          end
        end
        FULL: begin
          if (out_fire) begin
            s_valid <= 1'b0;
            m_ctrl  <= s_ctrl;
            m_data  <= s_data;
          end
        end
        default: begin
          m_valid <= 1'b0;
          s_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic stall_evt, flush_evt;

  assign stall_evt = m_valid && !out_ready;
  assign flush_evt = flush && (m_valid || s_valid || in_fire);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (perf_clr) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_evt && stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + 1'b1;
      if (flush_evt && flush_cnt != CNT_MAX) flush_cnt <= flush_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed self-checking bench for pipe_stage_skid (counters checked when
// PIPE_STAGE_PERF_EN is defined).
module tb_pipe_stage_skid;

  localparam int CTRL_W = 3;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
`ifdef PIPE_STAGE_PERF_EN
  logic              perf_clr;
  logic [1:0]        stall_cnt;
  logic [1:0]        flush_cnt;
`endif

  int checks = 0;
  int errors = 0;

  pipe_stage_skid #(
    .CTRL_W(CTRL_W),
    .DATA_W(DATA_W)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .CNT_W (2)
`endif
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_ctrl  (in_ctrl),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ctrl (out_ctrl),
    .out_data (out_data)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .perf_clr (perf_clr),
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Occupancy (0,1) shows up at the ports as out_valid=0 with in_ready=0.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checks++;
      assert (!(out_valid === 1'b0 && in_ready === 1'b0)) else begin
        errors++;
        $error("FAIL illegal_state observed=01 expected=not01");
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_ctrl   = '0;
    in_data   = '0;
    out_ready = 1'b0;
`ifdef PIPE_STAGE_PERF_EN
    perf_clr  = 1'b0;
`endif
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_ctrl",  32'(out_ctrl),  32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    rst_n = 1'b1;

    // Streaming at one beat per cycle.
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_ctrl  = 3'b101;
      in_data  = 8'(i);
      step();
      check("stream_valid", 32'(out_valid), 32'd1);
      check("stream_data",  32'(out_data),  32'(i));
      check("stream_ctrl",  32'(out_ctrl),  32'b101);
      check("stream_ready", 32'(in_ready),  32'd1);
    end
    in_valid = 1'b0;
    step();
    check("stream_drain_valid", 32'(out_valid), 32'd0);
    check("stream_drain_ctrl",  32'(out_ctrl),  32'd0);

    // Backpressure: beats 1 and 2 captured, beat 3 held upstream.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'd1;
    step();
    check("bp_b1_data",  32'(out_data), 32'd1);
    check("bp_b1_ready", 32'(in_ready), 32'd1);
    in_data = 8'd2;
    step();
    check("bp_full_ready", 32'(in_ready), 32'd0);
    check("bp_full_data",  32'(out_data), 32'd1);
    in_data = 8'd3;
    step();
    check("bp_hold_ready", 32'(in_ready), 32'd0);
    check("bp_hold_data",  32'(out_data), 32'd1);
    out_ready = 1'b1;
    step();
    check("bp_rel_data2",  32'(out_data), 32'd2);
    check("bp_rel_ready",  32'(in_ready), 32'd1);
    step();
    check("bp_rel_data3",  32'(out_data),  32'd3);
    check("bp_rel_valid3", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    step();
    check("bp_drain_valid", 32'(out_valid), 32'd0);

    // Bubble gating: control must stay zero while nothing is valid.
    in_ctrl = 3'b111;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bubble_ctrl",  32'(out_ctrl),  32'd0);
      check("bubble_valid", 32'(out_valid), 32'd0);
    end

    // Flush while FULL with an incoming beat.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ctrl   = 3'b101;
    in_data   = 8'h11;
    step();
    in_data = 8'h22;
    step();
    check("fl_full_ready", 32'(in_ready), 32'd0);
    in_data = 8'h33;
    flush   = 1'b1;
    step();
    check("fl_valid", 32'(out_valid), 32'd0);
    check("fl_ctrl",  32'(out_ctrl),  32'd0);
    check("fl_ready", 32'(in_ready),  32'd1);
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check("fl_nothing_valid", 32'(out_valid), 32'd0);
    end

    // Asynchronous reset between edges while FULL.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h44;
    step();
    in_data = 8'h55;
    step();
    check("ar_full_ready", 32'(in_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_out_valid", 32'(out_valid), 32'd0);
    check("ar_out_ctrl",  32'(out_ctrl),  32'd0);
    check("ar_out_data",  32'(out_data),  32'd0);
    check("ar_in_ready",  32'(in_ready),  32'd1);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'hA5;
    step();
    check("ar_new_valid", 32'(out_valid), 32'd1);
    check("ar_new_data",  32'(out_data),  32'hA5);
    in_valid = 1'b0;
    step();
    check("ar_alone_valid", 32'(out_valid), 32'd0);

`ifdef PIPE_STAGE_PERF_EN
    // Counters with CNT_W=2 saturate at 3.
    perf_clr = 1'b1;
    step();
    perf_clr = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h01;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("cnt_stall_sat", 32'(stall_cnt), 32'd3);
    perf_clr = 1'b1;
    step();
    perf_clr = 1'b0;
    check("cnt_clr_stall", 32'(stall_cnt), 32'd0);
    check("cnt_clr_flush", 32'(flush_cnt), 32'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("cnt_flush1", 32'(flush_cnt), 32'd1);
    in_valid = 1'b1;
    in_data  = 8'h09;
    step();
    in_valid = 1'b0;
    flush    = 1'b1;
    step();
    check("cnt_flush2", 32'(flush_cnt), 32'd2);
    step();
    flush = 1'b0;
    check("cnt_flush_empty", 32'(flush_cnt), 32'd2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline stage register with a valid/ready handshake, an internal two-entry skid buffer, and synchronous flush. It replaces the fixed-field stall/flush stage registers between pipeline stages (e.g. MEM→WB). Upstream backpressure is fully registered, so `in_ready` has no combinational path from `out_ready`. Control bits are gated to zero whenever the stage holds no valid instruction, so bubbles can never assert register writes.

## Interface
Parameters:
- `CTRL_W`, default 3: control-field width (e.g. reg_wr + sel_wb).
- `DATA_W`, default 101: datapath-field width (e.g. alu_o + rd_data + PC4 + rd).
- `CNT_W`, default 16: performance-counter width. Used only with `PIPE_STAGE_PERF_EN`.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst_n`, in, 1: reset. Asynchronous, active-low.
- `flush`, in, 1: synchronous kill of all held and incoming entries.
- `in_valid`, in, 1: upstream beat valid.
- `in_ready`, out, 1: stage can accept a beat. Registered.
- `in_ctrl`, in, CTRL_W: upstream control field.
- `in_data`, in, DATA_W: upstream datapath field.
- `out_valid`, out, 1: downstream beat valid.
- `out_ready`, in, 1: downstream accepts the beat. Replaces the stall input: stall = !out_ready.
- `out_ctrl`, out, CTRL_W: control field. Forced to 0 when `out_valid`=0.
- `out_data`, out, DATA_W: datapath field. Holds its last value when invalid.
- `perf_clr`, in, 1: clears the counters. Present only with `PIPE_STAGE_PERF_EN`.
- `stall_cnt`, out, CNT_W: backpressure cycle count. Present only with `PIPE_STAGE_PERF_EN`.
- `flush_cnt`, out, CNT_W: count of flushes that discarded entries. Present only with `PIPE_STAGE_PERF_EN`.

## Operation
- Storage: a main register (`m_valid`, `m_ctrl`, `m_data`) and a skid register (`s_valid`, `s_ctrl`, `s_data`).
- Outputs:
  - `out_valid` = `m_valid`.
  - `out_data` = `m_data`.
  - `out_ctrl` = `m_ctrl` when `m_valid`, else 0.
- `in_ready` = !`s_valid`.
- Handshakes: in_fire = `in_valid` & `in_ready`; out_fire = `out_valid` & `out_ready`.
- States, derived from {`m_valid`, `s_valid`}:
  - EMPTY (0,0):
    - in_fire → BUSY; main ← in.
  - BUSY (1,0):
    - in_fire & out_fire → BUSY; main ← in.
    - in_fire & !out_fire → FULL; skid ← in.
    - !in_fire & out_fire → EMPTY.
    - Otherwise hold.
  - FULL (1,1), where `in_ready`=0:
    - out_fire → BUSY; main ← skid.
    - Otherwise hold.
- `flush`=1 at a clock edge:
  - Next state is EMPTY; `m_valid` and `s_valid` are cleared.
  - A beat accepted (in_fire) in the flush cycle is discarded.
  - An out_fire in the flush cycle counts as delivered; the consumer owns it.
  - Data registers are not cleared by flush.
- Flush overrides out_ready/backpressure. This is required: a stalled stage must still be killable.
- Ordering is strict FIFO. The skid entry is always younger than the main entry.
- Illegal state (0,1) must be unreachable. The bench asserts this.
- `in_valid`, `in_ctrl` and `in_data` may change freely when `in_ready`=0.

## Timing
- Reset (`rst_n`=0), effective immediately and asynchronously:
  - Valids = 0.
  - All ctrl and data registers = 0.
  - `out_valid`=0, `out_ctrl`=0, `out_data`=0, `in_ready`=1.
  - Counters = 0.
- Release of `rst_n` is synchronised externally. The first accept is possible at the first edge after release.
- Reset mid-operation discards all entries, with no partial outputs.
- Latency: in_fire at edge N → `out_valid`=1 with that beat after edge N.
- Throughput: 1 beat/cycle sustained when `out_ready`=1.
- After `out_ready` drops, the stage accepts at most one further beat. `in_ready` falls in the cycle after that beat is captured.
- Recovery: FULL → BUSY on the out_fire edge. `in_ready`=1 in the following cycle.
- Flush at edge N → `out_valid`=0 and `out_ctrl`=0 after edge N; `in_ready`=1.

## Configuration
- `PIPE_STAGE_PERF_EN` defined: ports `perf_clr`, `stall_cnt` and `flush_cnt` exist.
  - `stall_cnt` increments each cycle with `out_valid`=1 & `out_ready`=0.
  - `flush_cnt` increments each flush cycle in which `m_valid`, `s_valid` or in_fire was 1.
  - Both counters saturate at 2^CNT_W−1.
  - `perf_clr` zeroes both counters, with priority over increment.
- Undefined: the three ports and all counter logic are absent. Handshake behaviour is identical.

## Test plan
- Reset then streaming: reset with `rst_n`=0, then stream beats ctrl=3'b101, data=1..8 with `out_ready`=1 → outputs 1..8 in order, one cycle after each accept, no gaps; `in_ready` stays 1.
- Backpressure: `out_ready`=0 while beats 1,2,3 are offered → beats 1 and 2 captured, `in_ready`=0, beat 3 held upstream. Raising `out_ready` then delivers 1,2,3 in order with no loss or duplication.
- Flush while FULL: flush with `out_ready`=0 and `in_valid`=1 → next cycle `out_valid`=0, `out_ctrl`=0, `in_ready`=1; neither held beat nor the incoming beat ever appears at the output.
- Bubble gating: `in_valid`=0 while `in_ctrl`=3'b111 → `out_ctrl` stays 3'b000 on every cycle.
- Async reset mid-stream: assert `rst_n`=0 between edges while FULL → outputs immediately 0 and `in_ready`=1; after release, new beat 0xA5 emerges alone.
- Counters (`PIPE_STAGE_PERF_EN` defined, CNT_W=2): stall 5 cycles → `stall_cnt`=3 (saturated); `perf_clr` → 0; two flushes of a non-empty stage → `flush_cnt`=2.
